// File: rtl/dfr_pkg.sv
// Shared definitions for the history capture controller: state encoding and
// default address/data widths.
package dfr_pkg;

  localparam int DFR_ADDR_WIDTH = 20;
  localparam int DFR_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/history_capture_ctrl_counter.sv
// Wrapping up-counter with synchronous clear (rst, has priority) and count enable.
module history_capture_ctrl_counter
  import dfr_pkg::*;
#(
  parameter int WIDTH = DFR_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (rst) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/history_capture_ctrl.sv
// Captures a run of reservoir samples into history RAM and arbitrates RAM
// readback against capture writes (writes always win).
module history_capture_ctrl
  import dfr_pkg::*;
#(
  parameter int ADDR_WIDTH = DFR_ADDR_WIDTH,
  parameter int DATA_WIDTH = DFR_DATA_WIDTH
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] num_samples,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_grant,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sample_count
);

  cap_state_t            state_reg;
  cap_state_t            state_next;
  logic [ADDR_WIDTH-1:0] num_reg;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_inc;
  logic                  wr_fire;
  logic                  ptr_clr;
  logic                  load_num;
  logic                  done_next;
  logic                  rd_grant_int;

  logic                  ram_wen_reg;
  logic [ADDR_WIDTH-1:0] ram_addr_reg;
  logic [DATA_WIDTH-1:0] ram_din_reg;
  logic                  rd_pend_reg;
  logic                  rd_valid_reg;
  logic                  done_reg;

  // Write pointer doubles as the sample count: both clear on start and step per write.
  history_capture_ctrl_counter #(
    .WIDTH(ADDR_WIDTH)
  ) u_wr_ptr (
    .clk  (S_AXI_ACLK),
    .rst_n(S_AXI_ARESETN),
    .rst  (ptr_clr),
    .en   (wr_fire),
    .count(wr_ptr)
  );

  assign wr_ptr_inc = wr_ptr + ADDR_WIDTH'(1);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wr_fire    = 1'b0;
    ptr_clr    = 1'b0;
    load_num   = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      ST_CAPTURE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (sample_valid) begin
          wr_fire = 1'b1;
          if (wr_ptr_inc == num_reg) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end
        end
      end
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          ptr_clr = 1'b1;
          if (num_samples != '0) begin
            load_num   = 1'b1;
            state_next = ST_CAPTURE;
          end else begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Gated by reset so a held request is never granted while the block is in reset.
  assign rd_grant_int = S_AXI_ARESETN && rd_req && !((state_reg == ST_CAPTURE) && sample_valid);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      num_reg      <= '0;
      ram_wen_reg  <= 1'b0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
      rd_pend_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg     <= done_next;
      ram_wen_reg  <= wr_fire;
      rd_pend_reg  <= rd_grant_int;
      rd_valid_reg <= rd_pend_reg;
      if (load_num) begin
        num_reg <= num_samples;
      end
      if (wr_fire) begin
        ram_addr_reg <= wr_ptr;
        ram_din_reg  <= sample_data;
      end else if (rd_grant_int) begin
        ram_addr_reg <= rd_addr;
      end
    end
  end

  assign rd_grant     = rd_grant_int;
  assign rd_valid     = rd_valid_reg;
  assign rd_data      = rd_valid_reg ? ram_dout : '0;
  assign ram_wen      = ram_wen_reg;
  assign ram_addr     = ram_addr_reg;
  assign ram_din      = ram_din_reg;
  assign busy         = (state_reg == ST_CAPTURE);
  assign done         = done_reg;
  assign sample_count = wr_ptr;

endmodule

// File: tb/tb_history_capture_ctrl.sv
// Directed and randomized checks of history_capture_ctrl against a
// transaction-level model of the capture run and readback pipeline.
module tb_history_capture_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] num_samples = '0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_grant;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;
  logic          done;
  logic [AW-1:0] sample_count;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [DW-1:0] last_rd = '0;

  always #5 clk = ~clk;

  history_capture_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .start        (start),
    .abort        (abort),
    .num_samples  (num_samples),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_grant     (rd_grant),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .ram_wen      (ram_wen),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count)
  );

  // Synchronous-read RAM attached to the DUT (2-state, so it powers up zeroed).
  bit [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Reference model: expected RAM image, run status and pending reads.
  bit [DW-1:0]   ref_mem [256];
  bit            m_busy = 1'b0;
  logic [AW-1:0] m_cnt = '0;
  logic [AW-1:0] m_num = '0;
  logic [AW-1:0] m_addr = '0;
  bit            s1_v = 1'b0;
  logic [DW-1:0] s1_d = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_cnt  = '0;
    m_num  = '0;
    m_addr = '0;
    s1_v   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_grant"}, rd_grant, 0);
    chk({tag, "_ram_wen"}, ram_wen, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
    chk({tag, "_sample_count"}, sample_count, 0);
  endtask

  // One clock cycle: drive inputs, check the combinational grant, then check
  // every registered output against the model after the edge.
  task automatic cyc(input bit st, input bit ab, input int num, input bit sv,
                     input logic [DW-1:0] sd, input bit rq, input int ra);
    bit            busy0, wr, gr, e_done, e_rv;
    logic [DW-1:0] e_rd;
    start        = st;
    abort        = ab;
    num_samples  = AW'(num);
    sample_valid = sv;
    sample_data  = sd;
    rd_req       = rq;
    rd_addr      = AW'(ra);
    #2;
    busy0 = m_busy;
    gr    = rq && !(busy0 && sv);
    chk("rd_grant", rd_grant, gr);
    @(posedge clk);
    #1;
    wr     = busy0 && sv && !ab;
    e_done = 1'b0;
    e_rv   = s1_v;
    e_rd   = s1_d;
    s1_v   = gr;
    s1_d   = ref_mem[AW'(ra)];
    if (wr) begin
      m_addr        = m_cnt;
      ref_mem[m_cnt] = sd;
      m_cnt         = m_cnt + AW'(1);
      if (m_cnt == m_num) begin
        m_busy = 1'b0;
        e_done = 1'b1;
      end
    end else if (gr) begin
      m_addr = AW'(ra);
    end
    if (busy0 && ab) begin
      m_busy = 1'b0;
    end else if (!busy0 && st && !ab) begin
      m_cnt = '0;
      if (num != 0) begin
        m_num  = AW'(num);
        m_busy = 1'b1;
      end else begin
        e_done = 1'b1;
      end
    end
    chk("ram_wen", ram_wen, wr);
    chk("ram_addr", ram_addr, m_addr);
    if (wr) chk("ram_din", ram_din, sd);
    chk("done", done, e_done);
    chk("busy", busy, m_busy);
    chk("sample_count", sample_count, m_cnt);
    chk("rd_valid", rd_valid, e_rv);
    if (e_rv) begin
      chk("rd_data", rd_data, e_rd);
      last_rd = rd_data;
      $display("RD data=0x%0h", rd_data);
    end
    if (wr) $display("WR addr=0x%0h data=0x%0h", m_addr, sd);
    if (done) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0, 0, 0);
  endtask

  // Reset asserted between edges with a read request held: everything must drop at once.
  task automatic async_rst(input string tag);
    start        = 1'b0;
    abort        = 1'b0;
    sample_valid = 1'b0;
    rd_req       = 1'b1;
    rd_addr      = AW'(3);
    #2 rst_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    check_zero({tag, "_held"});
    rst_n  = 1'b1;
    rd_req = 1'b0;
    $display("RESET %s", tag);
  endtask

  initial begin
    int d0;

    // Power-on reset
    rd_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");
    rst_n  = 1'b1;
    rd_req = 1'b0;
    model_reset();
    idle(2);

    // Four-sample run with data 0x10..0x13, then sample_valid ignored in DONE
    d0 = done_cnt;
    cyc(1, 0, 4, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, DW'(32'h10 + i), 0, 0);
    cyc(0, 0, 0, 1, DW'(32'hdead), 0, 0);
    idle(2);
    chk("run4_count", sample_count, 4);
    chk("run4_done_once", done_cnt - d0, 1);
    chk("run4_not_busy", busy, 0);
    chk("run4_mem3", mem[3], 32'h13);

    // Toggling valid, abort after three writes
    d0 = done_cnt;
    cyc(1, 0, 8, 0, '0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, (i % 2) == 0, DW'(32'h20 + i), 0, 0);
    cyc(0, 1, 0, 0, '0, 0, 0);
    idle(2);
    chk("abort_count", sample_count, 3);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", busy, 0);

    // Readback blocked by a capture write, granted once valid drops
    cyc(1, 0, 8, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, DW'(32'h30 + i), 0, 0);
    cyc(0, 0, 0, 1, DW'(32'h34), 1, 2);
    cyc(0, 0, 0, 0, '0, 1, 2);
    idle(2);
    chk("rd_stored_sample", last_rd, 32'h32);
    cyc(0, 1, 0, 0, '0, 0, 0);
    idle(1);

    // Start with abort stays idle; start with zero length completes at once
    cyc(1, 1, 5, 0, '0, 0, 0);
    chk("start_abort_idle", busy, 0);
    idle(1);
    d0 = done_cnt;
    cyc(1, 0, 0, 0, '0, 0, 0);
    idle(1);
    chk("zero_len_done", done_cnt - d0, 1);
    chk("zero_len_count", sample_count, 0);

    // Maximum-length run; a start mid-run must be ignored
    d0 = done_cnt;
    cyc(1, 0, 255, 0, '0, 0, 0);
    for (int i = 0; i < 255; i++) cyc(i == 10, 0, 3, 1, DW'($urandom), 0, 0);
    idle(2);
    chk("max_run_count", sample_count, 255);
    chk("max_run_done_once", done_cnt - d0, 1);

    // Reset mid-capture after two writes with a read in flight
    cyc(1, 0, 8, 0, '0, 0, 0);
    cyc(0, 0, 0, 1, DW'(32'h55), 0, 0);
    cyc(0, 0, 0, 1, DW'(32'h56), 0, 0);
    cyc(0, 0, 0, 0, '0, 1, 1);
    async_rst("midrun");
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, int'($urandom_range(0, 12)),
          bit'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 15)));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
